calc_cmd_issuer: RTL and testbench
==================================

Name: calc_cmd_issuer

Overview:
- Initiator side of the calculator command interface (Go / next / MS / Din in, CS_out / Dout out).
- Replays a small loaded program of (MS, Din) commands into the FSM/Datapath pair, one command at a time.
- For each command it pulses Go and waits for the FSM's done state. It then captures Dout, pulses next and waits for the FSM to return to idle.
- Used for self-running board demos and as the stimulus engine for system-level checks.

Parameters:
DEPTH, 8, number of program entries (address width 3)
IDLE_CS, 4'd0, CS_out encoding of the FSM idle state
DONE_CS, 4'd7, CS_out encoding of the FSM done/display state
TIMEOUT, 31, max cycles spent waiting for either CS value before error

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
prog_we  input  1  program write strobe
prog_addr  input  3  program write address
prog_data  input  19  {MS[2:0], Din[15:0]} entry
prog_len  input  4  number of entries to run (0..8)
start  input  1  begin running the program from entry 0
CS_in  input  4  FSM current state (from CS_out)
Dout_in  input  16  datapath result (from Dout)
Go  output  1  one-cycle command strobe to FSM
next  output  1  one-cycle advance strobe to FSM
MS  output  3  mode select to FSM/Datapath
Din  output  16  data to Datapath
busy  output  1  high from start accept until FINISH/ERR
done  output  1  one-cycle pulse when the program completes
err  output  1  sticky timeout flag
result  output  16  last captured Dout_in
result_valid  output  1  one-cycle pulse per captured result
idx  output  3  index of the entry currently being issued

Behaviour:
- Reset values: Go, next, busy, done, err, result_valid = 0; MS = 0; Din = 0; result = 0; idx = 0; state IDLE.
- Reset mid-run aborts the run immediately. Program memory is NOT cleared by reset.
- Program memory:
  - Writes occur on a CLK edge when prog_we=1 and busy=0.
  - Writes while busy=1 are ignored.
  - Memory is read combinationally at idx.
- States IDLE, LOAD, WAITDONE, CAPTURE, NEXT, WAITIDLE, FINISH, ERR.
- IDLE:
  - start=1 with prog_len=0 -> FINISH, without issuing any command.
  - start=1 with prog_len>8 is treated as 8.
  - Otherwise, start=1 -> latch prog_len, set idx=0, set busy=1, go to LOAD.
- LOAD:
  - Drive MS/Din from mem[idx]; they stay stable until the next LOAD.
  - Go=1 for exactly this cycle.
  - Clear the timeout counter; go to WAITDONE.
- WAITDONE:
  - CS_in==DONE_CS -> CAPTURE.
  - Else increment the counter; counter==TIMEOUT -> ERR.
- CAPTURE:
  - result <= Dout_in; result_valid=1 for one cycle.
  - Go to NEXT.
- NEXT:
  - next=1 for exactly one cycle; clear the counter.
  - Go to WAITIDLE.
- WAITIDLE:
  - CS_in==IDLE_CS -> if idx==len-1 then FINISH, else idx<=idx+1 and go to LOAD.
  - Else increment the counter; timeout -> ERR.
- FINISH: done=1 for one cycle; busy=0; go to IDLE.
- ERR:
  - err=1 (sticky), busy=0; go to IDLE.
  - err clears only on an accepted start or on RST.
- start while busy is ignored.
- Go and next are never high in the same cycle.
- Go/next latency: Go rises 2 cycles after start is sampled; next rises 2 cycles after DONE_CS is first sampled.
- The counter saturates; TIMEOUT compare is equality on a 5-bit counter.
- DONE_CS seen already at LOAD+1 is accepted (zero-wait FSM).

Test Plan:
- Load 3 entries {MS=1,Din=16'h0005}, {MS=1,Din=16'h0003}, {MS=2,Din=0}; prog_len=3; start. Model FSM reaches DONE_CS 4 cycles after each Go with Dout=16'h0008 on the last entry. Required: 3 Go pulses, 3 next pulses, 3 result_valid pulses, final result=16'h0008, one done pulse, busy low after it.
- prog_len=0, start -> done pulse 1 cycle later; Go and next never asserted; err=0.
- Model FSM never reaches DONE_CS -> err=1 exactly TIMEOUT+1 cycles after the Go pulse; busy=0; next never asserted. A new start clears err.
- Assert RST in WAITDONE of entry 2 -> next cycle all outputs at reset values. Rerun start -> execution restarts at idx=0 with the original program intact.
- prog_we during busy to addr 0 with 16'hFFFF -> ignored; a subsequent run still issues the original entry 0 Din.
- start pulsed again mid-run -> no effect on idx or sequence; exactly prog_len Go pulses total.

Source files
------------

// File: rtl/calc_cmd_issuer_if.sv
// Command link between the issuer (master) and the calculator FSM/datapath pair (slave).
interface calc_cmd_issuer_if;
  logic        Go;
  logic        next;
  logic [2:0]  MS;
  logic [15:0] Din;
  logic [3:0]  CS_in;
  logic [15:0] Dout_in;

  modport master (output Go, next, MS, Din, input CS_in, Dout_in);
  modport slave  (input Go, next, MS, Din, output CS_in, Dout_in);
endinterface

// File: rtl/calc_cmd_issuer.sv
// Replays a stored program of (MS, Din) commands into the calculator FSM,
// handshaking on its CS encoding and capturing each Dout result.
module calc_cmd_issuer #(
  parameter int         DEPTH   = 8,
  parameter logic [3:0] IDLE_CS = 4'd0,
  parameter logic [3:0] DONE_CS = 4'd7,
  parameter logic [4:0] TIMEOUT = 5'd31
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                prog_we,
  input  logic [2:0]          prog_addr,
  input  logic [18:0]         prog_data,
  input  logic [3:0]          prog_len,
  input  logic                start,
  calc_cmd_issuer_if.master   cmd,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         result,
  output logic                result_valid,
  output logic [2:0]          idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAITDONE, S_CAPTURE, S_NEXT, S_WAITIDLE, S_FINISH, S_ERR
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'(DEPTH);

  state_t      state_q, state_d;
  logic [18:0] mem [DEPTH];
  logic [18:0] entry;
  logic [3:0]  len_q;
  logic [4:0]  cnt_q, cnt_inc;
  logic        go_q;
  logic [2:0]  ms_q;
  logic [15:0] din_q;
  logic        next_pulse;
  logic        cs_done, cs_idle, cnt_hit, last_entry;

  assign entry      = mem[idx];
  assign cs_done    = (cmd.CS_in == DONE_CS);
  assign cs_idle    = (cmd.CS_in == IDLE_CS);
  assign cnt_hit    = (cnt_q == TIMEOUT);
  assign cnt_inc    = (cnt_q == 5'h1f) ? cnt_q : cnt_q + 5'd1;
  assign last_entry = ({1'b0, idx} == len_q - 4'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = (prog_len == 4'd0) ? S_FINISH : S_LOAD;
      S_LOAD:     state_d = S_WAITDONE;
      S_WAITDONE: begin
        if (cs_done)      state_d = S_CAPTURE;
        else if (cnt_hit) state_d = S_ERR;
      end
      S_CAPTURE:  state_d = S_NEXT;
      S_NEXT:     state_d = S_WAITIDLE;
      S_WAITIDLE: begin
        if (cs_idle)      state_d = last_entry ? S_FINISH : S_LOAD;
        else if (cnt_hit) state_d = S_ERR;
      end
      S_FINISH:   state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    next_pulse = (state_q == S_NEXT);
    done       = (state_q == S_FINISH);
    busy       = (state_q == S_LOAD)    || (state_q == S_WAITDONE) ||
                 (state_q == S_CAPTURE) || (state_q == S_NEXT)     ||
                 (state_q == S_WAITIDLE);
  end

  // NOTE: program memory has no reset so a board reset keeps the loaded demo.
  always_ff @(posedge CLK) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  // Go is registered alongside MS/Din so the FSM sees all three together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      go_q         <= 1'b0;
      ms_q         <= '0;
      din_q        <= '0;
      idx          <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      go_q         <= (state_q == S_LOAD);
      result_valid <= (state_q == S_CAPTURE);
      case (state_q)
        S_IDLE: if (start) begin
          idx   <= '0;
          len_q <= (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
          err   <= 1'b0;
        end
        S_LOAD: begin
          ms_q  <= entry[18:16];
          din_q <= entry[15:0];
          cnt_q <= '0;
        end
        S_WAITDONE: if (!cs_done) cnt_q <= cnt_inc;
        S_CAPTURE:  result <= cmd.Dout_in;
        S_NEXT:     cnt_q <= '0;
        S_WAITIDLE: begin
          if (cs_idle) begin
            if (!last_entry) idx <= idx + 3'd1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: ;
      endcase
      if (state_d == S_ERR) err <= 1'b1;
    end
  end

  assign cmd.Go   = go_q;
  assign cmd.next = next_pulse;
  assign cmd.MS   = ms_q;
  assign cmd.Din  = din_q;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Directed bench for calc_cmd_issuer with a small behavioural calculator FSM
// (MS=1 accumulates Din, MS=2 shows the accumulator).
module tb_calc_cmd_issuer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_addr = '0;
  logic [18:0] prog_data = '0;
  logic [3:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        busy, done, err, result_valid;
  logic [15:0] result;
  logic [2:0]  idx;

  logic        hang = 1'b0;
  logic        model_clr = 1'b0;
  logic [2:0]  dly = '0;
  logic [2:0]  ms_l = '0;
  logic [15:0] din_l = '0;
  logic [15:0] acc = '0;

  int go_cnt = 0, next_cnt = 0, rv_cnt = 0, done_cnt = 0, both_cnt = 0;
  int go_b, next_b, rv_b, done_b;
  int vectors = 0, miscompares = 0;
  int n;

  calc_cmd_issuer_if cmd ();

  calc_cmd_issuer dut (
    .CLK(CLK), .RST(RST), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .cmd(cmd),
    .busy(busy), .done(done), .err(err), .result(result),
    .result_valid(result_valid), .idx(idx)
  );

  always #5 CLK = ~CLK;

  // Calculator FSM model: DONE_CS four edges after Go, IDLE_CS after next.
  always @(posedge CLK) begin
    if (RST || model_clr) begin
      cmd.CS_in   <= 4'd0;
      cmd.Dout_in <= '0;
      acc         <= '0;
      dly         <= '0;
    end else begin
      if (cmd.Go) begin
        dly   <= 3'd4;
        ms_l  <= cmd.MS;
        din_l <= cmd.Din;
      end else if (dly != 3'd0) begin
        dly <= dly - 3'd1;
        if (dly == 3'd1 && !hang) begin
          cmd.CS_in <= 4'd7;
          case (ms_l)
            3'd1: begin acc <= acc + din_l; cmd.Dout_in <= acc + din_l; end
            3'd2: cmd.Dout_in <= acc;
            default: cmd.Dout_in <= din_l;
          endcase
        end
      end
      if (cmd.next) cmd.CS_in <= 4'd0;
    end
  end

  always @(posedge CLK) begin
    if (cmd.Go)              go_cnt   <= go_cnt + 1;
    if (cmd.next)            next_cnt <= next_cnt + 1;
    if (result_valid)        rv_cnt   <= rv_cnt + 1;
    if (done)                done_cnt <= done_cnt + 1;
    if (cmd.Go && cmd.next)  both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic prog_write(input logic [2:0] a, input logic [2:0] ms, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = {ms, d};
    step();
    prog_we = 1'b0;
  endtask

  task automatic run_start(input logic [3:0] len);
    prog_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr_model();
    model_clr = 1'b1;
    step();
    model_clr = 1'b0;
  endtask

  task automatic take_bases();
    go_b = go_cnt; next_b = next_cnt; rv_b = rv_cnt; done_b = done_cnt;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_go",     32'(cmd.Go), 32'd0);
    check("rst_next",   32'(cmd.next), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_err",    32'(err), 32'd0);
    check("rst_rv",     32'(result_valid), 32'd0);
    check("rst_ms",     32'(cmd.MS), 32'd0);
    check("rst_din",    32'(cmd.Din), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_idx",    32'(idx), 32'd0);
    RST = 1'b0;
    step();

    prog_write(3'd0, 3'd1, 16'h0005);
    prog_write(3'd1, 3'd1, 16'h0003);
    prog_write(3'd2, 3'd2, 16'h0000);
    for (int i = 3; i < 8; i++) prog_write(3'(i), 3'd1, 16'h0001);

    // Three-entry program, latency of Go and next on the first entry.
    clr_model(); take_bases();
    run_start(4'd3);
    check("t1_busy",  32'(busy), 32'd1);
    check("t1_go_ld", 32'(cmd.Go), 32'd0);
    check("t1_idx",   32'(idx), 32'd0);
    step();
    check("t1_go",  32'(cmd.Go), 32'd1);
    check("t1_ms",  32'(cmd.MS), 32'd1);
    check("t1_din", 32'(cmd.Din), 32'h5);
    n = 0;
    while (cmd.CS_in !== 4'd7 && n < 50) begin step(); n++; end
    check("t1_cs_done", 32'(cmd.CS_in), 32'd7);
    step();
    check("t1_next_cap", 32'(cmd.next), 32'd0);
    step();
    check("t1_next", 32'(cmd.next), 32'd1);
    check("t1_rv",   32'(result_valid), 32'd1);
    check("t1_res0", 32'(result), 32'h5);
    wait_done(300);
    check("t1_busy_fin", 32'(busy), 32'd0);
    step();
    check("t1_done_low", 32'(done), 32'd0);
    check("t1_go_n",   32'(go_cnt - go_b), 32'd3);
    check("t1_next_n", 32'(next_cnt - next_b), 32'd3);
    check("t1_rv_n",   32'(rv_cnt - rv_b), 32'd3);
    check("t1_done_n", 32'(done_cnt - done_b), 32'd1);
    check("t1_result", 32'(result), 32'h8);

    // Empty program finishes without issuing commands.
    take_bases();
    run_start(4'd0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    step();
    check("t2_done_low", 32'(done), 32'd0);
    check("t2_go_n",   32'(go_cnt - go_b), 32'd0);
    check("t2_next_n", 32'(next_cnt - next_b), 32'd0);
    check("t2_err",    32'(err), 32'd0);

    // FSM never reaches DONE: timeout TIMEOUT+1 cycles after Go.
    clr_model(); hang = 1'b1; take_bases();
    run_start(4'd1);
    step();
    check("t3_go", 32'(cmd.Go), 32'd1);
    n = 0;
    while (err !== 1'b1 && n < 100) begin step(); n++; end
    check("t3_err_lat", 32'(n), 32'd32);
    check("t3_err",     32'(err), 32'd1);
    check("t3_busy",    32'(busy), 32'd0);
    check("t3_next_n",  32'(next_cnt - next_b), 32'd0);
    hang = 1'b0;
    clr_model();
    check("t3_err_sticky", 32'(err), 32'd1);
    run_start(4'd1);
    check("t3_err_clr", 32'(err), 32'd0);
    wait_done(200);
    step();
    check("t3_result", 32'(result), 32'h5);

    // Reset while waiting on entry index 1, then rerun from entry 0.
    clr_model();
    run_start(4'd3);
    n = 0;
    while (!(cmd.Go === 1'b1 && idx === 3'd1) && n < 100) begin step(); n++; end
    check("t4_at_entry1", 32'(cmd.Go), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t4_go",     32'(cmd.Go), 32'd0);
    check("t4_busy",   32'(busy), 32'd0);
    check("t4_idx",    32'(idx), 32'd0);
    check("t4_din",    32'(cmd.Din), 32'd0);
    check("t4_result", 32'(result), 32'd0);
    check("t4_next",   32'(cmd.next), 32'd0);
    take_bases();
    run_start(4'd3);
    step();
    check("t4_go2",  32'(cmd.Go), 32'd1);
    check("t4_din2", 32'(cmd.Din), 32'h5);
    wait_done(300);
    step();
    check("t4_go_n",  32'(go_cnt - go_b), 32'd3);
    check("t4_res",   32'(result), 32'h8);

    // Program write while busy is dropped.
    clr_model();
    run_start(4'd1);
    check("t5_busy", 32'(busy), 32'd1);
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = {3'd1, 16'hFFFF};
    step();
    prog_we = 1'b0;
    check("t5_din_a", 32'(cmd.Din), 32'h5);
    wait_done(200);
    step();
    clr_model();
    run_start(4'd1);
    step();
    check("t5_din_b", 32'(cmd.Din), 32'h5);
    wait_done(200);
    step();
    check("t5_result", 32'(result), 32'h5);

    // Start held high mid-run is ignored.
    clr_model(); take_bases();
    run_start(4'd3);
    step();
    start = 1'b1;
    repeat (5) step();
    start = 1'b0;
    check("t6_idx",    32'(idx), 32'd0);
    check("t6_go_mid", 32'(go_cnt - go_b), 32'd1);
    wait_done(300);
    step();
    check("t6_go_n",  32'(go_cnt - go_b), 32'd3);
    check("t6_res",   32'(result), 32'h8);

    // Oversized length runs all eight entries: 5+3, show 8, then +1 x5.
    clr_model(); take_bases();
    run_start(4'd12);
    wait_done(600);
    step();
    check("t7_go_n",   32'(go_cnt - go_b), 32'd8);
    check("t7_next_n", 32'(next_cnt - next_b), 32'd8);
    check("t7_res",    32'(result), 32'hD);
    check("go_next_overlap", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
